m_w_stage: RTL

- Memory-to-Writeback pipeline register plus writeback datapath for the 5-stage MIPS core.
- Latches M-stage results each cycle.
- Extends load data by type and byte offset, and selects the writeback source.
- Drives W_RegWrite / W_A3 / W_RegData / W_PC directly into the D-stage register file, which forwards W data internally; also keeps a retired-instruction counter.

---
 rtl/m_w_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/m_w_stage.sv
// Memory-to-Writeback pipeline register with load extension, writeback mux and retire counter.
// Optional macro WB_TRACE_EN prints each committed GRF write to the simulation log.
module m_w_stage #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] PC_OFFSET = 32'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_en,
    input  logic             M_flush,
    input  logic             M_valid,
    input  logic [31:0]      M_PC,
    input  logic             M_RegWrite,
    input  logic [4:0]       M_A3,
    input  logic [1:0]       M_WBSel,
    input  logic [31:0]      M_ALUResult,
    input  logic [31:0]      M_MemRData,
    input  logic [2:0]       M_LoadType,
    input  logic [31:0]      M_HiLo,
    output logic             W_RegWrite,
    output logic [4:0]       W_A3,
    output logic [31:0]      W_RegData,
    output logic [31:0]      W_PC,
    output logic             W_valid,
    output logic [CNT_W-1:0] W_RetireCnt
);

    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       a3_q, a3_d;
    logic [1:0]       wb_sel_q, wb_sel_d;
    logic [31:0]      alu_result_q, alu_result_d;
    logic [31:0]      mem_rdata_q, mem_rdata_d;
    logic [2:0]       load_type_q, load_type_d;
    logic [31:0]      hilo_q, hilo_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Flush takes priority over enable; a bubble still carries M_PC for tracing.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        reg_write_d  = reg_write_q;
        a3_d         = a3_q;
        wb_sel_d     = wb_sel_q;
        alu_result_d = alu_result_q;
        mem_rdata_d  = mem_rdata_q;
        load_type_d  = load_type_q;
        hilo_d       = hilo_q;
        retire_cnt_d = retire_cnt_q + CNT_W'(valid_q);
        if (M_flush) begin
            valid_d      = 1'b0;
            pc_d         = M_PC;
            reg_write_d  = 1'b0;
            a3_d         = 5'd0;
            wb_sel_d     = 2'd0;
            alu_result_d = 32'd0;
            mem_rdata_d  = 32'd0;
            load_type_d  = 3'd0;
            hilo_d       = 32'd0;
        end else if (M_en) begin
            valid_d      = M_valid;
            pc_d         = M_PC;
            reg_write_d  = M_RegWrite;
            a3_d         = M_A3;
            wb_sel_d     = M_WBSel;
            alu_result_d = M_ALUResult;
            mem_rdata_d  = M_MemRData;
            load_type_d  = M_LoadType;
            hilo_d       = M_HiLo;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            pc_q         <= 32'd0;
            reg_write_q  <= 1'b0;
            a3_q         <= 5'd0;
            wb_sel_q     <= 2'd0;
            alu_result_q <= 32'd0;
            mem_rdata_q  <= 32'd0;
            load_type_q  <= 3'd0;
            hilo_q       <= 32'd0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            reg_write_q  <= reg_write_d;
            a3_q         <= a3_d;
            wb_sel_q     <= wb_sel_d;
            alu_result_q <= alu_result_d;
            mem_rdata_q  <= mem_rdata_d;
            load_type_q  <= load_type_d;
            hilo_q       <= hilo_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    logic [7:0]  mem_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_byte[gi] = mem_rdata_q[8*gi +: 8];
        end
    endgenerate

    // Halfword lane comes from offset[1] only; misalignment is trapped upstream.
    always_comb begin
        sel_byte = mem_byte[alu_result_q[1:0]];
        sel_half = alu_result_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];
        case (load_type_q)
            3'd1:    load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'd2:    load_ext = {24'd0, sel_byte};
            3'd3:    load_ext = {{16{sel_half[15]}}, sel_half};
            3'd4:    load_ext = {16'd0, sel_half};
            default: load_ext = mem_rdata_q;
        endcase
    end

    always_comb begin
        case (wb_sel_q)
            2'd0:    W_RegData = alu_result_q;
            2'd1:    W_RegData = load_ext;
            2'd2:    W_RegData = pc_q + PC_OFFSET;
            default: W_RegData = hilo_q;
        endcase
    end

    assign W_RegWrite  = reg_write_q & valid_q & (a3_q != 5'd0);
    assign W_A3        = a3_q;
    assign W_PC        = pc_q;
    assign W_valid     = valid_q;
    assign W_RetireCnt = retire_cnt_q;

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (reset && W_RegWrite)
            $display("@%h: $%0d <= %h", W_PC, W_A3, W_RegData);
    end
`endif

endmodule
